// File: rtl/pipe_pkg.sv
// Shared pipeline package: default datapath widths and the write-back bundle layout.
// The MEM/WB and EX/MEM registers store their bundles in the same packed order:
// valid, rd, reg_write, mem_to_reg, halt, then the data fields.
// wb_bundle_t is that layout at the default widths. Parameterised users declare
// their own struct with the same field order.
package pipe_pkg;

    localparam int PIPE_DATA_W = 16;
    localparam int PIPE_REG_AW = 4;
    localparam int PIPE_PC_W   = 16;
    localparam int PIPE_CNT_W  = 16;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_AW-1:0] rd;
        logic                   regWrite;
        logic                   memToReg;
        logic                   halt;
        logic [PIPE_DATA_W-1:0] memData;
        logic [PIPE_DATA_W-1:0] aluResult;
        logic [PIPE_PC_W-1:0]   pcNext;
    } wb_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   in   clock, posedge
//   clr   in   synchronous clear (highest priority)
//   inc   in   add one this edge unless the counter is already at its maximum
//   count out  current value, sticks at 2^CNT_W-1
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid bit, stall, flush, halt freeze and
// saturating retire/bubble counters.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   wen, flush               1 = advance / insert a bubble this edge
//   d_*                      incoming write-back bundle from the memory stage
//   q_valid, q_rd            registered valid bit and destination register
//   q_reg_write              register-file write strobe, masked while halted
//   q_wb_data                mem_to_reg ? mem_data : alu_result (combinational)
//   q_halt, q_pc_next        registered qualified halt and next PC
//   halted                   sticky, set once a valid HLT sits in this stage
//   retire_cnt, bubble_cnt   saturating counts of captured instructions / bubbles
//
// Handshake: wen=1 captures the d_* bundle at the edge (1-cycle latency);
// wen=0 holds. flush=1 loads a bubble regardless of wen. Once halted is set,
// nothing but rst changes any state.
module memwb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int PC_W   = PIPE_PC_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_mem_data,
    input  logic [DATA_W-1:0] d_alu_result,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_reg_write,
    input  logic              d_mem_to_reg,
    input  logic              d_halt,
    input  logic [PC_W-1:0]   d_pc_next,
    output logic              q_valid,
    output logic [REG_AW-1:0] q_rd,
    output logic              q_reg_write,
    output logic [DATA_W-1:0] q_wb_data,
    output logic              q_halt,
    output logic [PC_W-1:0]   q_pc_next,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Same field order as pipe_pkg::wb_bundle_t, at this instance's widths.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regWrite;
        logic              memToReg;
        logic              halt;
        logic [DATA_W-1:0] memData;
        logic [DATA_W-1:0] aluResult;
        logic [PC_W-1:0]   pcNext;
    } bundle_t;

    bundle_t bundleQ;
    bundle_t bundleD;
    logic    captureEn;
    logic    flushEn;
    logic    retireInc;
    logic    bubbleInc;

    always_comb begin
        bundleD           = '0;
        bundleD.valid     = d_valid;
        bundleD.rd        = d_rd;
        // Strobes are qualified on capture so a bubble can never write or halt.
        bundleD.regWrite  = d_reg_write & d_valid;
        bundleD.memToReg  = d_mem_to_reg;
        bundleD.halt      = d_halt & d_valid;
        bundleD.memData   = d_mem_data;
        bundleD.aluResult = d_alu_result;
        bundleD.pcNext    = d_pc_next;
    end

    // Freeze dominates flush, flush dominates the stall.
    always_comb begin
        flushEn   = ~halted & flush;
        captureEn = ~halted & ~flush & wen;
        retireInc = captureEn & d_valid;
        bubbleInc = flushEn | (captureEn & ~d_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundleQ <= '0;
            halted  <= 1'b0;
        end else if (!halted) begin
            // The HLT already in the stage arms the freeze on this edge;
            // the edge itself still follows the normal flush/capture rules.
            if (bundleQ.valid && bundleQ.halt) begin
                halted <= 1'b1;
            end
            if (flushEn) begin
                bundleQ <= '0;
            end else if (captureEn) begin
                bundleQ <= bundleD;
            end
        end
    end

    always_comb begin
        q_valid     = bundleQ.valid;
        q_rd        = bundleQ.rd;
        q_reg_write = bundleQ.regWrite & ~halted;
        q_wb_data   = bundleQ.memToReg ? bundleQ.memData : bundleQ.aluResult;
        q_halt      = bundleQ.halt;
        q_pc_next   = bundleQ.pcNext;
    end

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (retireInc),
        .count (retire_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (bubbleInc),
        .count (bubble_cnt)
    );

endmodule
